rr_arbiter8: RTL and testbench

Eight-way round-robin arbiter that turns raw, possibly multi-hot request lines into a registered, strictly one-hot grant vector. It sits directly upstream of the 8-to-3 encoder: `grant` connects to the encoder's 8-bit input, so the encoder only ever sees a legal one-hot code or all-zero. A valid/ready handshake holds each grant stable until the downstream stage accepts it. Priority rotates so that every persistent requester is served within eight accepted grants.

---
 rtl/rr_arbiter8.sv | 84 ++++++++
 tb/tb_rr_arbiter8.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant held under a
// valid/ready handshake; priority rotates past each accepted winner.
module rr_arbiter8 #(
    parameter int unsigned RESET_PTR = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       grant_ready,
    output logic [7:0] grant,
    output logic       grant_valid,
    output logic [2:0] ptr
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] ptr_q, ptr_d;

    logic [2:0] win_idx;
    logic [2:0] arb_base;
    logic [2:0] scan_idx;
    logic [7:0] arb_grant;

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (grant_q[i]) win_idx = 3'(i);
        end
    end

    // On accept the search starts just past the current winner, which is also the new pointer.
    assign arb_base = (state_q == GRANT) ? 3'(win_idx + 3'd1) : ptr_q;

    always_comb begin
        arb_grant = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            scan_idx = 3'(arb_base + 3'(k));
            if (arb_grant == '0 && req[scan_idx]) arb_grant[scan_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (state_q == IDLE) begin
            if (req != '0) begin
                grant_d = arb_grant;
                state_d = GRANT;
            end
        end else if (grant_ready) begin
            ptr_d = arb_base;
            if (req != '0) begin
                grant_d = arb_grant;
            end else begin
                grant_d = '0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= 3'(RESET_PTR);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = (state_q == GRANT);
    assign ptr         = ptr_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: a rotate-and-find-first reference model
// queues expected outputs per edge; a monitor pops and compares them.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       grant_ready = 1'b0;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] ptr;

    always #5 clk = ~clk;

    rr_arbiter8 #(.RESET_PTR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant_ready(grant_ready),
        .grant      (grant),
        .grant_valid(grant_valid),
        .ptr        (ptr)
    );

    typedef struct packed {
        logic [7:0] g;
        logic       v;
        logic [2:0] p;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    bit         m_valid = 1'b0;
    int         m_win = 0;
    int         m_ptr = 0;
    int         wait_cnt[8];
    logic [7:0] prev_grant = '0;
    logic       prev_valid = 1'b0;

    function automatic int pick(input logic [7:0] r, input int p);
        logic [15:0] d;
        logic [7:0]  rot;
        logic [7:0]  lsb;
        d   = {r, r};
        rot = 8'(d >> p);
        lsb = rot & (~rot + 8'd1);
        return (p + $clog2(lsb)) % 8;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic [7:0] r, input logic rdy);
        exp_t e;
        @(negedge clk);
        req         = r;
        grant_ready = rdy;
        if (m_valid && rdy) begin
            m_ptr = (m_win + 1) % 8;
            if (r != 8'h00) m_win = pick(r, m_ptr);
            else m_valid = 1'b0;
        end else if (!m_valid && r != 8'h00) begin
            m_win   = pick(r, m_ptr);
            m_valid = 1'b1;
        end
        e.g = m_valid ? 8'(1 << m_win) : 8'h00;
        e.v = m_valid;
        e.p = 3'(m_ptr);
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n       = 1'b0;
        req         = '0;
        grant_ready = 1'b0;
        #1;
        check("rst_grant", grant, 8'h00);
        check("rst_valid", grant_valid, 1'b0);
        check("rst_ptr", ptr, 3'd0);
        m_valid = 1'b0;
        m_ptr   = 0;
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
                prev_valid = 1'b0;
                prev_grant = '0;
                continue;
            end
            for (int i = 0; i < 8; i++) begin
                if (!req[i]) begin
                    wait_cnt[i] = 0;
                end else if (prev_valid && grant_ready) begin
                    if (prev_grant[i]) begin
                        wait_cnt[i] = 0;
                    end else begin
                        wait_cnt[i]++;
                        check($sformatf("starve%0d", i), 32'(wait_cnt[i] > 7), 32'd0);
                    end
                end
            end
            if (grant_valid) check("onehot", 32'($onehot(grant)), 32'd1);
            else check("idle_zero", grant, 8'h00);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("grant", grant, e.g);
                check("valid", grant_valid, e.v);
                check("ptr", ptr, e.p);
            end
            prev_grant = grant;
            prev_valid = grant_valid;
        end
    end

    initial begin
        logic [7:0] persist;
        logic [7:0] r;
        for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
        #1;
        check("por_grant", grant, 8'h00);
        check("por_valid", grant_valid, 1'b0);
        check("por_ptr", ptr, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset in the middle of a held grant of 8'h10
        cycle(8'h10, 1'b0);
        cycle(8'h10, 1'b0);
        do_reset();
        repeat (3) cycle(8'h00, 1'b0);

        // single requester repeats
        repeat (5) cycle(8'h20, 1'b1);

        // full rotation with wrap
        do_reset();
        repeat (10) cycle(8'hFF, 1'b1);

        // backpressure then accept
        do_reset();
        repeat (6) cycle(8'h0C, 1'b0);
        cycle(8'h08, 1'b1);
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b1);

        // drain to idle from 8'h80
        do_reset();
        cycle(8'h80, 1'b0);
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b1);

        // random stress
        do_reset();
        persist = 8'($urandom);
        for (int n = 0; n < 10000; n++) begin
            if (n % 64 == 0) persist = 8'($urandom);
            r = persist | (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 15) == 0) r = 8'h00;
            cycle(r, $urandom_range(0, 9) < 7);
        end
        repeat (3) cycle(8'h00, 1'b1);

        @(posedge clk);
        #2;
        check("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
